// File: rtl/n64_cfg_regs.sv
`default_nettype none
// ============================================================================
// Module      : n64_cfg_regs
// Description : N64-side command/config register window. Presents STATUS/CMD,
//               DATA0, DATA1 and IDENTIFIER as 16-bit halfwords, latches
//               N64 commands, pulses a one-cycle request to the CPU, and
//               absorbs CPU result writes into DATA0/DATA1.
//               Optional macro N64_CFG_IRQ_EN enables the completion IRQ.
// Revision    : 1.0 - initial release
// ============================================================================
module n64_cfg_regs #(
    parameter logic [31:0] IDENTIFIER = 32'h53437632
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reg_access,
    input  logic        reg_write,
    input  logic [2:0]  reg_address,
    input  logic [15:0] reg_wdata,
    output logic [15:0] reg_rdata,
    output logic        reg_ack,
    input  logic        cpu_ready,
    input  logic        cpu_busy,
    input  logic        cmd_error,
    output logic        cmd_request,
    output logic [7:0]  cmd,
    output logic [31:0] data0,
    output logic [31:0] data1,
    input  logic [1:0]  data_write,
    input  logic [31:0] wdata,
    output logic        irq
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] REQUEST   = 2'd1;
    localparam logic [1:0] WAIT_BUSY = 2'd2;
    localparam logic [1:0] WAIT_DONE = 2'd3;

    logic [1:0]  r_state;
    logic        r_pending;
    logic        r_ack;
    logic [15:0] r_rdata;
    logic [7:0]  r_cmd;
    logic [31:0] r_data0;
    logic [31:0] r_data1;

    logic [1:0]  w_reg_sel;
    logic        w_low_half;
    logic        w_wr;
    logic        w_rd;
    logic        w_busy;
    logic        w_cmd_accept;
    logic        w_done;
    logic        w_irq_flag;
    logic [15:0] w_status_hi;
    logic [15:0] w_rdata;

    assign w_reg_sel    = reg_address[2:1];
    assign w_low_half   = reg_address[0];
    assign w_wr         = reg_access & reg_write;
    assign w_rd         = reg_access & ~reg_write;
    assign w_busy       = cpu_busy | r_pending;
    // A command is only taken when the CPU is up and nothing is outstanding
    assign w_cmd_accept = w_wr & (w_reg_sel == 2'd0) & w_low_half & cpu_ready & ~w_busy;
    // Command completion: CPU has dropped busy after having picked the command up
    assign w_done       = (r_state == WAIT_DONE) & ~cpu_busy & cpu_ready;
    assign w_status_hi  = {w_busy, cmd_error, cpu_ready, w_irq_flag, 12'b0};

    // Read-side register mux
    always_comb begin
        w_rdata = 16'h0000;
        case (w_reg_sel)
            2'd0:    w_rdata = w_low_half ? 16'h0000 : w_status_hi;
            2'd1:    w_rdata = w_low_half ? r_data0[15:0] : r_data0[31:16];
            2'd2:    w_rdata = w_low_half ? r_data1[15:0] : r_data1[31:16];
            default: w_rdata = w_low_half ? IDENTIFIER[15:0] : IDENTIFIER[31:16];
        endcase
    end

    // Access completion: ack one cycle after the strobe, read data captured with it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ack   <= 1'b0;
            r_rdata <= 16'h0000;
        end else begin
            r_ack <= reg_access;
            if (w_rd) begin
                r_rdata <= w_rdata;
            end
        end
    end

    // DATA0/DATA1 halfword writes from the N64; a CPU write to the same register wins
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data0 <= 32'h0;
            r_data1 <= 32'h0;
        end else begin
            if (data_write[0]) begin
                r_data0 <= wdata;
            end else if (w_wr && w_reg_sel == 2'd1) begin
                if (w_low_half) r_data0[15:0]  <= reg_wdata;
                else            r_data0[31:16] <= reg_wdata;
            end
            if (data_write[1]) begin
                r_data1 <= wdata;
            end else if (w_wr && w_reg_sel == 2'd2) begin
                if (w_low_half) r_data1[15:0]  <= reg_wdata;
                else            r_data1[31:16] <= reg_wdata;
            end
        end
    end

    // Command sequencer: request pulse, then track the CPU's busy handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_pending <= 1'b0;
            r_cmd     <= 8'h00;
        end else if (!cpu_ready) begin
            r_state   <= IDLE;
            r_pending <= 1'b0;
        end else begin
            if (w_cmd_accept) begin
                r_cmd     <= reg_wdata[7:0];
                r_pending <= 1'b1;
            end else if (cpu_busy) begin
                r_pending <= 1'b0;
            end
            if (w_cmd_accept) begin
                r_state <= REQUEST;
            end else begin
                case (r_state)
                    REQUEST:   r_state <= WAIT_BUSY;
                    WAIT_BUSY: if (cpu_busy)  r_state <= WAIT_DONE;
                    WAIT_DONE: if (!cpu_busy) r_state <= IDLE;
                    default:   r_state <= IDLE;
                endcase
            end
        end
    end

`ifdef N64_CFG_IRQ_EN
    logic r_irq_flag;
    logic w_irq_clr;

    assign w_irq_clr = w_wr & (w_reg_sel == 2'd0) & ~w_low_half & reg_wdata[15];

    // Completion interrupt flag; a completion in the same cycle as a clear keeps it set
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq_flag <= 1'b0;
        end else if (w_done) begin
            r_irq_flag <= 1'b1;
        end else if (w_irq_clr) begin
            r_irq_flag <= 1'b0;
        end
    end

    assign w_irq_flag = r_irq_flag;
`else
    logic w_done_unused;
    assign w_done_unused = w_done;
    assign w_irq_flag    = 1'b0;
`endif

    assign reg_ack     = r_ack;
    assign reg_rdata   = r_rdata;
    assign cmd_request = (r_state == REQUEST);
    assign cmd         = r_cmd;
    assign data0       = r_data0;
    assign data1       = r_data1;
    assign irq         = w_irq_flag;

endmodule
`default_nettype wire

// File: tb/tb_n64_cfg_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_n64_cfg_regs
// Description : Self-checking bench for n64_cfg_regs. A cycle model derived
//               from the register map and command handshake runs beside the
//               DUT; outputs are compared every cycle, plus literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_n64_cfg_regs;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        reg_access = 1'b0;
    logic        reg_write = 1'b0;
    logic [2:0]  reg_address = 3'd0;
    logic [15:0] reg_wdata = 16'h0;
    logic [15:0] reg_rdata;
    logic        reg_ack;
    logic        cpu_ready = 1'b0;
    logic        cpu_busy = 1'b0;
    logic        cmd_error = 1'b0;
    logic        cmd_request;
    logic [7:0]  cmd;
    logic [31:0] data0;
    logic [31:0] data1;
    logic [1:0]  data_write = 2'b00;
    logic [31:0] wdata = 32'h0;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    n64_cfg_regs dut (
        .clk         (clk),
        .reset       (reset),
        .reg_access  (reg_access),
        .reg_write   (reg_write),
        .reg_address (reg_address),
        .reg_wdata   (reg_wdata),
        .reg_rdata   (reg_rdata),
        .reg_ack     (reg_ack),
        .cpu_ready   (cpu_ready),
        .cpu_busy    (cpu_busy),
        .cmd_error   (cmd_error),
        .cmd_request (cmd_request),
        .cmd         (cmd),
        .data0       (data0),
        .data1       (data1),
        .data_write  (data_write),
        .wdata       (wdata),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 request issued, 2 waiting for busy, 3 waiting for done
    int          m_phase = 0;
    bit          m_pend = 0, m_irq = 0, m_ack = 0, m_rd_seen = 0;
    logic [15:0] m_rdata = 16'h0;
    logic [7:0]  m_cmd = 8'h0;
    logic [31:0] m_d0 = 32'h0, m_d1 = 32'h0;

    always @(posedge clk) begin
        int          idx;
        bit          lo, wr, accept, done, clr, busy_view;
        logic [31:0] id_val;
        logic [31:0] regs [4];
        logic [15:0] status_hi;
        if (reset) begin
            m_phase = 0; m_pend = 0; m_irq = 0; m_ack = 0;
            m_rdata = 16'h0; m_cmd = 8'h0; m_d0 = 32'h0; m_d1 = 32'h0;
        end else begin
            idx       = int'(reg_address[2:1]);
            lo        = reg_address[0];
            wr        = reg_access && reg_write;
            busy_view = cpu_busy || m_pend;
            status_hi = {busy_view, cmd_error, cpu_ready, m_irq, 12'b0};
            id_val    = 32'h53437632;
            regs[0]   = {status_hi, 16'h0000};
            regs[1]   = m_d0;
            regs[2]   = m_d1;
            regs[3]   = id_val;
            m_ack     = reg_access;
            if (reg_access && !reg_write) begin
                m_rdata   = lo ? regs[idx][15:0] : regs[idx][31:16];
                m_rd_seen = 1;
            end
            accept = wr && idx == 0 && lo && cpu_ready && !busy_view;
            done   = (m_phase == 3) && !cpu_busy && cpu_ready;
            clr    = wr && idx == 0 && !lo && reg_wdata[15];
            if (wr && idx == 1) begin
                if (lo) m_d0[15:0] = reg_wdata; else m_d0[31:16] = reg_wdata;
            end
            if (wr && idx == 2) begin
                if (lo) m_d1[15:0] = reg_wdata; else m_d1[31:16] = reg_wdata;
            end
            if (data_write[0]) m_d0 = wdata;
            if (data_write[1]) m_d1 = wdata;
            if (!cpu_ready) begin
                m_phase = 0;
                m_pend  = 0;
            end else if (accept) begin
                m_cmd   = reg_wdata[7:0];
                m_pend  = 1;
                m_phase = 1;
            end else begin
                if (cpu_busy) m_pend = 0;
                if (m_phase == 1)                  m_phase = 2;
                else if (m_phase == 2 && cpu_busy) m_phase = 3;
                else if (m_phase == 3 && !cpu_busy) m_phase = 0;
            end
`ifdef N64_CFG_IRQ_EN
            if (done)     m_irq = 1;
            else if (clr) m_irq = 0;
`else
            m_irq = 0;
`endif
        end
    end

    // ---------------- compare process ----------------
    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("ack",         {31'b0, reg_ack},     {31'b0, m_ack});
            cmp("cmd_request", {31'b0, cmd_request}, {31'b0, m_phase == 1});
            cmp("cmd",         {24'b0, cmd},         {24'b0, m_cmd});
            cmp("data0",       data0,                m_d0);
            cmp("data1",       data1,                m_d1);
            cmp("irq",         {31'b0, irq},         {31'b0, m_irq});
            if (m_rd_seen) cmp("rdata", {16'b0, reg_rdata}, {16'b0, m_rdata});
        end
    end

    // ---------------- stimulus ----------------
    // Called right after a negedge; returns at the negedge where ack is high.
    task automatic acc(input bit wr, input logic [2:0] a, input logic [15:0] d,
                       input logic [1:0] dw = 2'b00, input logic [31:0] cw = 32'h0);
        reg_access  = 1'b1;
        reg_write   = wr;
        reg_address = a;
        reg_wdata   = d;
        data_write  = dw;
        wdata       = cw;
        @(negedge clk);
        reg_access = 1'b0;
        reg_write  = 1'b0;
        data_write = 2'b00;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        tick(3);
        reset  = 1'b0;
        chk_en = 1'b1;
        cmp("reset_ack",   {31'b0, reg_ack}, 32'h0);
        cmp("reset_data0", data0, 32'h0);
        cmp("reset_cmd",   {24'b0, cmd}, 32'h0);

        // Identifier halves
        acc(1'b0, 3'b110, 16'h0);
        cmp("id_hi", {16'b0, reg_rdata}, 32'h5343);
        cmp("id_ack", {31'b0, reg_ack}, 32'h1);
        acc(1'b0, 3'b111, 16'h0);
        cmp("id_lo", {16'b0, reg_rdata}, 32'h7632);
        tick(1);
        cmp("ack_drop", {31'b0, reg_ack}, 32'h0);

        // Command with DATA0 argument
        cpu_ready = 1'b1;
        acc(1'b1, 3'b010, 16'h1234);
        acc(1'b1, 3'b011, 16'h5678);
        cmp("d0_arg", data0, 32'h12345678);
        acc(1'b1, 3'b001, 16'h00AB);
        cmp("cmd_ab", {24'b0, cmd}, 32'hAB);
        cmp("req_hi", {31'b0, cmd_request}, 32'h1);
        acc(1'b0, 3'b000, 16'h0);
        cmp("req_lo", {31'b0, cmd_request}, 32'h0);
        cmp("stat_busy", {16'b0, reg_rdata}, 32'hA000);

        // Busy: command dropped but acked
        cpu_busy = 1'b1;
        tick(2);
        acc(1'b1, 3'b001, 16'h00CD);
        cmp("drop_cmd", {24'b0, cmd}, 32'hAB);
        cmp("drop_ack", {31'b0, reg_ack}, 32'h1);

        // CPU write collides with N64 write to DATA0 high
        acc(1'b1, 3'b010, 16'h0000, 2'b01, 32'hDEADBEEF);
        cmp("cpu_wins", data0, 32'hDEADBEEF);
        // CPU writes DATA1 while N64 writes DATA0 low: both land
        acc(1'b1, 3'b011, 16'h1111, 2'b10, 32'hCAFEF00D);
        cmp("both_d0", data0, 32'hDEAD1111);
        cmp("both_d1", data1, 32'hCAFEF00D);
        acc(1'b1, 3'b100, 16'hAAAA, 2'b11, 32'h0BADF00D);
        cmp("dw11_d0", data0, 32'h0BADF00D);
        cmp("dw11_d1", data1, 32'h0BADF00D);

        // Completion
        cpu_busy = 1'b0;
        tick(1);
`ifdef N64_CFG_IRQ_EN
        cmp("irq_set", {31'b0, irq}, 32'h1);
        acc(1'b0, 3'b000, 16'h0);
        cmp("stat_irq", {16'b0, reg_rdata}, 32'h3000);
        acc(1'b1, 3'b000, 16'h8000);
        cmp("irq_clr", {31'b0, irq}, 32'h0);
`else
        cmp("irq_off", {31'b0, irq}, 32'h0);
`endif
        cmd_error = 1'b1;
        acc(1'b0, 3'b000, 16'h0);
        cmp("stat_err", {16'b0, reg_rdata}, 32'h6000);
        cmd_error = 1'b0;
        acc(1'b0, 3'b001, 16'h0);
        cmp("stat_lo", {16'b0, reg_rdata}, 32'h0);

        // cpu_ready low: command dropped
        cpu_ready = 1'b0;
        acc(1'b1, 3'b001, 16'h0010);
        cmp("nready_cmd", {24'b0, cmd}, 32'hAB);
        // cpu_ready drops while waiting for busy
        cpu_ready = 1'b1;
        acc(1'b1, 3'b001, 16'h0011);
        cmp("cmd_11", {24'b0, cmd}, 32'h11);
        tick(1);
        cpu_ready = 1'b0;
        tick(1);
        cpu_ready = 1'b1;
        acc(1'b0, 3'b000, 16'h0);
        cmp("abort_stat", {16'b0, reg_rdata}, 32'h2000);

        // Completion and IRQ clear in the same cycle
        acc(1'b1, 3'b001, 16'h0022);
        cpu_busy = 1'b1;
        tick(2);
        cpu_busy = 1'b0;
        acc(1'b1, 3'b000, 16'h8000);
`ifdef N64_CFG_IRQ_EN
        cmp("irq_set_wins", {31'b0, irq}, 32'h1);
`endif
        cmp("cmd_22", {24'b0, cmd}, 32'h22);

        // Reset in the middle of a command
        acc(1'b1, 3'b001, 16'h0033);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        cmp("rst_cmd",   {24'b0, cmd}, 32'h0);
        cmp("rst_req",   {31'b0, cmd_request}, 32'h0);
        cmp("rst_data1", data1, 32'h0);
        cmp("rst_irq",   {31'b0, irq}, 32'h0);
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/n64_cfg_regs.md
Name: n64_cfg_regs

Overview:
- N64-side command/config register window. Sits between the PI register-access path and the N64 side of the shared config interface, on the consumer side of the CPU's status/data writes.
- Exposes four 32-bit registers to the N64 as 16-bit halfwords: STATUS/CMD, DATA0, DATA1 and IDENTIFIER.
- Latches commands and arguments written by the N64, and raises a one-cycle command request toward the CPU.
- Also absorbs the CPU's result writes into DATA0/DATA1.

Parameters:
- IDENTIFIER, 32'h53437632, constant value returned by register 3.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- reg_access  in  1  one-cycle register access strobe from the PI block
- reg_write  in  1  1 = write, 0 = read; qualified by reg_access
- reg_address  in  3  halfword index; [2:1] selects the register, [0]=0 high half, [0]=1 low half
- reg_wdata  in  16  write halfword
- reg_rdata  out  16  read halfword
- reg_ack  out  1  one-cycle completion pulse
- cpu_ready  in  1  CPU firmware is running
- cpu_busy  in  1  CPU is executing a command
- cmd_error  in  1  last command failed
- cmd_request  out  1  one-cycle command pulse to the CPU
- cmd  out  8  latched command code
- data0  out  32  argument/result register 0
- data1  out  32  argument/result register 1
- data_write  in  2  CPU write strobes; [0] targets DATA0, [1] targets DATA1
- wdata  in  32  CPU write data
- irq  out  1  N64 interrupt; present only with the optional feature

Behaviour:
- Reset values: reg_rdata=0, reg_ack=0, cmd_request=0, cmd=0, data0=0, data1=0, irq=0, pending=0.
- One access per reg_access pulse. reg_ack is asserted exactly 1 cycle after the strobe, for both reads and writes.
  - Read: reg_rdata is valid in the same cycle as reg_ack and holds until the next access.
  - Write: takes effect in the strobe's next cycle, i.e. the cycle reg_ack is high.
- Register map, read side:
  - Reg 0 (STATUS) high half = {cpu_busy|pending, cmd_error, cpu_ready, irq_flag, 12'b0}; low half = 0.
  - Reg 1 and reg 2 return DATA0 and DATA1.
  - Reg 3 returns IDENTIFIER.
- Register map, write side:
  - Reg 0, low half: latches cmd=reg_wdata[7:0] and pulses cmd_request for one cycle.
  - Reg 0, high half: writing 1 to bit 15 clears irq_flag (feature only); all other bits are ignored.
  - Reg 1 / reg 2: halfword write into the selected half of DATA0 / DATA1.
  - Reg 3: writes ignored.
- Command guard:
  - pending is set on an accepted command write and cleared on the first cycle cpu_busy is seen high after it.
  - A reg-0 low-half write while cpu_busy|pending=1, or while cpu_ready=0, is acked but dropped: no cmd update, no cmd_request.
- FSM states: IDLE, REQUEST, WAIT_BUSY, WAIT_DONE.
  - IDLE -> REQUEST on an accepted command write.
  - REQUEST -> WAIT_BUSY after 1 cycle; cmd_request is high only in REQUEST.
  - WAIT_BUSY -> WAIT_DONE when cpu_busy=1.
  - WAIT_DONE -> IDLE when cpu_busy=0.
  - cpu_ready falling in any state -> IDLE with pending cleared.
- Simultaneous CPU data_write and N64 write to the same register in the same cycle: the CPU write wins for all 32 bits.
  - If data_write targets the other register, both writes take effect.
  - data_write=2'b11 writes wdata to both registers.
- N64 writes to DATA0/DATA1 while a command is in progress are allowed. No interlock; firmware protocol forbids them.
- Reset mid-command: all state returns to reset values. A cmd_request pulse already issued is not retracted.

Optional Feature:
- Macro: N64_CFG_IRQ_EN.
- Defined:
  - irq_flag is set on the WAIT_DONE -> IDLE transition and cleared by writing 1 to STATUS bit 15.
  - irq = irq_flag.
  - If set and clear occur in the same cycle, set wins.
- Undefined: irq is tied to 0, STATUS bit 12 reads 0, and bit-15 writes are ignored.

Test Plan:
- Reset, then read reg 3 high/low -> rdata 16'h5343 then 16'h7632; reg_ack exactly 1 cycle after each strobe.
- cpu_ready=1, write DATA0 halves 16'h1234 then 16'h5678, then STATUS low 16'h00AB -> data0=32'h12345678, cmd=8'hAB, cmd_request high for exactly 1 cycle; STATUS read -> bit 15=1.
- With cpu_busy=1, write STATUS low 16'h00CD -> cmd stays 8'hAB, no cmd_request, reg_ack still pulses.
- Same cycle: CPU data_write=2'b01, wdata=32'hDEADBEEF, and N64 write of 16'h0000 to DATA0 high -> data0=32'hDEADBEEF.
- cpu_ready=0, write command 8'h10 -> dropped. Then command in flight and cpu_ready drops in WAIT_BUSY -> FSM returns to IDLE and STATUS bit 15 reads 0.
- N64_CFG_IRQ_EN: command completes (cpu_busy 1 -> 0) -> irq=1 next cycle; write STATUS high 16'h8000 -> irq=0. Set and clear in the same cycle -> irq stays 1.
